param_reload_counter: RTL and testbench
=======================================

Name: param_reload_counter

Overview:
- Parametrised successor to the lab 4-bit reload-at-10 down counter.
- Configurable width and reload value, runtime-loadable terminal value, up/down direction, auto-reload or one-shot mode, and a registered terminal-count pulse.
- Used as the general timer/sequencer primitive in later labs, for example to drive shift-register load strobes.

Parameters:
- WIDTH, 4, counter and load-value width in bits (2..16).
- RELOAD_DEFAULT, 10, reload/terminal value after reset; must fit in WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous active-low reset.
- Clear  input  1  synchronous clear.
- Enable  input  1  count enable.
- Load  input  1  synchronous load strobe; acts regardless of Enable.
- Load_val  input  WIDTH  new reload/terminal value, sampled when Load=1.
- Up  input  1  direction: 1 = count up, 0 = count down.
- One_shot  input  1  mode: 1 = one-shot, 0 = auto-reload.
- Q  output  WIDTH  current count.
- Tc  output  1  registered one-cycle terminal-count pulse.
- Busy  output  1  high while the FSM is in RUN.

Behaviour:
- Registers:
  - count (drives Q).
  - rld, the reload/terminal value, WIDTH bits.
  - 2-bit state: IDLE, RUN, DONE.
  - Tc flop.
- Reset (Reset_n=0, async): count=0, rld=RELOAD_DEFAULT, state=IDLE, Tc=0, Busy=0. Takes effect immediately, including mid-count.
- Start value S: Up=0 gives S=rld; Up=1 gives S=0.
- Terminal value T: Up=0 gives T=0; Up=1 gives T=rld.
- Priority per rising edge: Clear > Load > Enable-count.
- Clear: count=0, state=IDLE, Tc=0. rld is kept.
- Load:
  - rld<=Load_val.
  - count<=Load_val if Up=0; count<=0 if Up=1.
  - state<=RUN; Tc<=0.
- IDLE:
  - Q holds. Enable alone does not count.
  - Enable=1 with One_shot=0: count<=S, state<=RUN.
  - One_shot=1: only Load leaves IDLE.
- RUN with Enable=1, count!=T: count moves one step toward T (decrement or increment).
- RUN with Enable=1, count==T:
  - Tc<=1.
  - One_shot=0: count<=S and stay in RUN (auto-reload). Down period = rld+1 enabled cycles.
  - One_shot=1: count holds T, state<=DONE.
- RUN with Enable=0: count, state and Tc=0 all hold.
- DONE: Q holds T, Busy=0. Only Load, Clear or reset leaves DONE.
- Tc:
  - High exactly one clk, in the cycle after the terminal edge.
  - Zero on every other cycle.
  - Back-to-back terminals (rld=0) give Tc high on consecutive cycles.
- rld=0: T==S, so every enabled RUN cycle is a terminal event. Auto mode gives Q=0 and Tc continuously high; one-shot reaches DONE on the first enabled cycle.
- Up/One_shot changing mid-count: the new S and T apply from the next edge. If count is already past the new T, counting continues to the natural wrap: down wraps via 0 to T; up wraps modulo 2^WIDTH to T. No X or lock-up.
- Busy = (state==RUN), combinational from the state register.
- Arithmetic: modulo 2^WIDTH, unsigned.

Optional Feature:
- Macro COUNTER_PRESCALE_EN.
- When defined:
  - Adds parameter PRESCALE (default 4, 1..256) and an internal prescale counter.
  - A count step or terminal event happens only on every PRESCALE-th enabled RUN cycle.
  - The prescaler resets to 0 on reset, Clear, Load or Enable=0 (resetting on Enable=0 is required).
  - Tc is still one clk wide.
- When undefined: no prescaler logic, every enabled RUN cycle steps, and the PRESCALE parameter does not exist.

Test Plan:
- Reset defaults, auto down: deassert Reset_n, One_shot=0, Up=0, Enable=1. Q: 0 (IDLE) -> 10,9,...,0,10. Tc high exactly one cycle after each Q==0 edge, period 11 cycles. Busy=1 from the first enabled cycle.
- Load mid-count: Up=0, Q=6, pulse Load with Load_val=3, Enable=0. Next cycle Q=3, Tc=0. Then Enable=1: Q 3,2,1,0,3.
- One-shot up: One_shot=1, Up=1, Load with Load_val=5, Enable=1. Q 0..5, Tc pulse once, state DONE, Busy=0, Q stays 5 for 20 cycles. A second Load restarts at 0.
- Priority: Clear, Load and Enable all high on one edge gives Q=0, IDLE, Tc=0, with rld unchanged (later Load_val is ignored). Reset_n low mid-count clears Q asynchronously before the next edge.
- Edge cases: Load_val=0 in auto mode gives Tc high every enabled cycle and Q=0. WIDTH=8, Load_val=255, Up=1: Q runs 0..255, Tc fires, Q wraps to 0.
- COUNTER_PRESCALE_EN, PRESCALE=4: Q steps every 4th enabled cycle. Dropping Enable for one cycle restarts the prescale phase.

Source files
------------

// File: rtl/param_reload_counter.sv
// param_reload_counter
//   Parametrised reload counter used as the general timer/sequencer primitive.
//   Configurable width and reload value, runtime-loadable terminal value,
//   up/down counting, auto-reload or one-shot mode, registered one-cycle
//   terminal-count pulse (Tc) and a Busy flag that is high while running.
//
//   Optional build macro: COUNTER_PRESCALE_EN
//     When defined, adds parameter PRESCALE (1..256). A count step or
//     terminal event then happens only on every PRESCALE-th enabled RUN cycle.
//     The prescale phase restarts on reset, Clear, Load or Enable=0.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | after reset/Clear; Q holds, waits for Enable (auto) or Load
//   RUN     | counting toward the terminal value; Busy=1
//   DONE    | one-shot finished; Q holds the terminal value until Load/Clear
module param_reload_counter #(
    parameter int WIDTH          = 4,
    parameter int RELOAD_DEFAULT = 10
`ifdef COUNTER_PRESCALE_EN
    ,
    parameter int PRESCALE       = 4
`endif
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             Clear,
    input  logic             Enable,
    input  logic             Load,
    input  logic [WIDTH-1:0] Load_val,
    input  logic             Up,
    input  logic             One_shot,
    output logic [WIDTH-1:0] Q,
    output logic             Tc,
    output logic             Busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] RLD_RST = WIDTH'(RELOAD_DEFAULT);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] rld_q, rld_d;
    state_t           state_q, state_d;
    logic             tc_q, tc_d;

    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] term_val;
    logic [WIDTH-1:0] step_val;
    logic             at_term;
    logic             step_ok;

    // Start/terminal values follow the current direction; the step wraps
    // modulo 2^WIDTH so a count that is past the terminal value after a
    // direction change simply runs around to it.
    always_comb begin
        start_val = Up ? '0 : rld_q;
        term_val  = Up ? rld_q : '0;
        step_val  = Up ? (count_q + ONE) : (count_q - ONE);
        at_term   = (count_q == term_val);
    end

`ifdef COUNTER_PRESCALE_EN
    localparam int            PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_q, pre_d;

    // Prescale phase advances only on enabled RUN cycles; any interruption
    // restarts it so the next step is a full PRESCALE cycles away.
    always_comb begin
        pre_d = pre_q;
        if (Clear || Load || !Enable || (state_q != ST_RUN)) begin
            pre_d = '0;
        end else if (pre_q == PRE_LAST) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + PRE_W'(1);
        end
        step_ok = (pre_q == PRE_LAST);
    end

    // Prescale phase register.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    // Without the prescaler every enabled RUN cycle is a step.
    always_comb begin
        step_ok = 1'b1;
    end
`endif

    // Next-state logic: Clear beats Load beats counting.
    always_comb begin
        count_d = count_q;
        rld_d   = rld_q;
        state_d = state_q;
        tc_d    = 1'b0;

        if (Clear) begin
            count_d = '0;
            state_d = ST_IDLE;
        end else if (Load) begin
            rld_d   = Load_val;
            count_d = Up ? '0 : Load_val;
            state_d = ST_RUN;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // One-shot mode is armed only by Load.
                    if (Enable && !One_shot) begin
                        count_d = start_val;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (Enable && step_ok) begin
                        if (at_term) begin
                            tc_d = 1'b1;
                            if (One_shot) begin
                                state_d = ST_DONE;
                            end else begin
                                count_d = start_val;
                            end
                        end else begin
                            count_d = step_val;
                        end
                    end
                end
                ST_DONE: begin
                    count_d = count_q;
                end
                default: begin
                    // Unreachable encoding recovers to a clean idle.
                    count_d = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, count, reload and terminal-pulse registers.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count_q <= '0;
            rld_q   <= RLD_RST;
            state_q <= ST_IDLE;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            rld_q   <= rld_d;
            state_q <= state_d;
            tc_q    <= tc_d;
        end
    end

    // Outputs: Q and Tc are straight from flops, Busy decodes the state.
    always_comb begin
        Q    = count_q;
        Tc   = tc_q;
        Busy = (state_q == ST_RUN);
    end

endmodule

// File: tb/tb_param_reload_counter.sv
// Self-checking bench for param_reload_counter: one WIDTH=4 instance (a) and
// one WIDTH=8 instance (b), each checked every cycle against a behavioural
// model, plus hand-computed literal expectations along the directed sequence.
module tb_param_reload_counter;

`ifdef COUNTER_PRESCALE_EN
    localparam int PS_A = 4;
`else
    localparam int PS_A = 1;
`endif

    logic       clk;
    logic       Reset_n;
    logic       a_clr, a_ld, a_en, a_up, a_os;
    logic [3:0] a_lv;
    logic [3:0] a_q;
    logic       a_tc, a_busy;
    logic       b_clr, b_ld, b_en, b_up, b_os;
    logic [7:0] b_lv;
    logic [7:0] b_q;
    logic       b_tc, b_busy;

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef COUNTER_PRESCALE_EN
    param_reload_counter #(.WIDTH(4), .RELOAD_DEFAULT(10), .PRESCALE(4)) dut_a (
`else
    param_reload_counter #(.WIDTH(4), .RELOAD_DEFAULT(10)) dut_a (
`endif
        .clk(clk), .Reset_n(Reset_n), .Clear(a_clr), .Enable(a_en), .Load(a_ld),
        .Load_val(a_lv), .Up(a_up), .One_shot(a_os), .Q(a_q), .Tc(a_tc), .Busy(a_busy));

`ifdef COUNTER_PRESCALE_EN
    param_reload_counter #(.WIDTH(8), .RELOAD_DEFAULT(10), .PRESCALE(1)) dut_b (
`else
    param_reload_counter #(.WIDTH(8), .RELOAD_DEFAULT(10)) dut_b (
`endif
        .clk(clk), .Reset_n(Reset_n), .Clear(b_clr), .Enable(b_en), .Load(b_ld),
        .Load_val(b_lv), .Up(b_up), .One_shot(b_os), .Q(b_q), .Tc(b_tc), .Busy(b_busy));

    // Behavioural model: running/done flags instead of a state encoding.
    typedef struct {
        int cnt;
        int rld;
        bit run;
        bit done;
        bit tc;
        int pre;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.cnt = 0; r.rld = 10; r.run = 0; r.done = 0; r.tc = 0; r.pre = 0;
        return r;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, int mask, int ps, bit clr, bit ld,
                                      bit en, bit up, bit os, int lv);
        mdl_t n;
        int   s;
        int   t;
        n    = m;
        n.tc = 0;
        s    = up ? 0 : m.rld;
        t    = up ? m.rld : 0;
        if (clr) begin
            n.cnt = 0; n.run = 0; n.done = 0; n.pre = 0;
        end else if (ld) begin
            n.rld = lv; n.cnt = up ? 0 : lv; n.run = 1; n.done = 0; n.pre = 0;
        end else if (m.run && en) begin
            n.pre = m.pre + 1;
            if (n.pre == ps) begin
                n.pre = 0;
                if (m.cnt == t) begin
                    n.tc = 1;
                    if (os) begin
                        n.run = 0; n.done = 1;
                    end else begin
                        n.cnt = s;
                    end
                end else begin
                    n.cnt = up ? ((m.cnt + 1) & mask) : ((m.cnt - 1) & mask);
                end
            end
        end else if (m.run) begin
            n.pre = 0;
        end else if (!m.done && en && !os) begin
            n.cnt = s; n.run = 1;
        end
        return n;
    endfunction

    initial begin
        ma = mdl_reset();
        mb = mdl_reset();
    end

    always @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ma = mdl_reset();
            mb = mdl_reset();
        end else begin
            ma = mdl_step(ma, 15, PS_A, a_clr, a_ld, a_en, a_up, a_os, int'(a_lv));
            mb = mdl_step(mb, 255, 1, b_clr, b_ld, b_en, b_up, b_os, int'(b_lv));
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        cmp("a_q", 32'(a_q), ma.cnt);
        cmp("a_tc", 32'(a_tc), 32'(ma.tc));
        cmp("a_busy", 32'(a_busy), 32'(ma.run));
        cmp("b_q", 32'(b_q), mb.cnt);
        cmp("b_tc", 32'(b_tc), 32'(mb.tc));
        cmp("b_busy", 32'(b_busy), 32'(mb.run));
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        Reset_n = 1'b0;
        a_clr = 0; a_ld = 0; a_en = 0; a_up = 0; a_os = 0; a_lv = '0;
        b_clr = 0; b_ld = 0; b_en = 0; b_up = 0; b_os = 0; b_lv = '0;
        tick(3);
        Reset_n = 1'b1;
        tick(1);
        cmp("lit_reset_q", 32'(a_q), 0);
        cmp("lit_reset_busy", 32'(a_busy), 0);
        cmp("lit_reset_tc", 32'(a_tc), 0);

`ifndef COUNTER_PRESCALE_EN
        // Auto down from reset defaults.
        a_en = 1;
        tick(1);  cmp("lit_auto_start", 32'(a_q), 10); cmp("lit_auto_busy", 32'(a_busy), 1);
        tick(10); cmp("lit_auto_zero", 32'(a_q), 0);
        tick(1);  cmp("lit_auto_reload", 32'(a_q), 10); cmp("lit_auto_tc", 32'(a_tc), 1);
        tick(1);  cmp("lit_auto_nine", 32'(a_q), 9); cmp("lit_auto_tc_low", 32'(a_tc), 0);
        // Load mid-count with Enable low.
        tick(3);  cmp("lit_six", 32'(a_q), 6);
        a_ld = 1; a_lv = 4'd3; a_en = 0;
        tick(1);  cmp("lit_load_q", 32'(a_q), 3); cmp("lit_load_tc", 32'(a_tc), 0);
        a_ld = 0;
        tick(1);  cmp("lit_hold_q", 32'(a_q), 3);
        a_en = 1;
        tick(3);  cmp("lit_load_zero", 32'(a_q), 0);
        tick(1);  cmp("lit_load_reload", 32'(a_q), 3); cmp("lit_load_tc1", 32'(a_tc), 1);
        // One-shot up.
        a_os = 1; a_up = 1; a_lv = 4'd5; a_ld = 1;
        tick(1);  cmp("lit_os_start", 32'(a_q), 0);
        a_ld = 0;
        tick(5);  cmp("lit_os_five", 32'(a_q), 5); cmp("lit_os_busy", 32'(a_busy), 1);
        tick(1);  cmp("lit_os_tc", 32'(a_tc), 1); cmp("lit_os_done", 32'(a_busy), 0);
        tick(20); cmp("lit_os_hold", 32'(a_q), 5); cmp("lit_os_tc0", 32'(a_tc), 0);
        a_ld = 1;
        tick(1);  cmp("lit_os_restart", 32'(a_q), 0); cmp("lit_os_rbusy", 32'(a_busy), 1);
        a_ld = 0;
        // Direction change mid-count in one-shot.
        tick(2);  cmp("lit_dir_two", 32'(a_q), 2);
        a_up = 0;
        tick(2);  cmp("lit_dir_zero", 32'(a_q), 0);
        tick(1);  cmp("lit_dir_tc", 32'(a_tc), 1); cmp("lit_dir_done", 32'(a_busy), 0);
        // Priority Clear > Load > Enable.
        a_os = 0; a_ld = 1;
        tick(1);  cmp("lit_pr_load", 32'(a_q), 5);
        a_ld = 0;
        tick(3);  cmp("lit_pr_two", 32'(a_q), 2);
        a_clr = 1; a_ld = 1; a_lv = 4'd9;
        tick(1);  cmp("lit_pr_q", 32'(a_q), 0); cmp("lit_pr_busy", 32'(a_busy), 0);
        a_clr = 0; a_ld = 0;
        tick(1);  cmp("lit_pr_rld_kept", 32'(a_q), 5);
        tick(2);  cmp("lit_pr_three", 32'(a_q), 3);
        // Asynchronous reset mid-count.
        Reset_n = 0;
        #1;
        cmp("lit_async_q", 32'(a_q), 0);
        cmp("lit_async_busy", 32'(a_busy), 0);
        tick(1);
        Reset_n = 1;
        tick(1);  cmp("lit_rst_rld", 32'(a_q), 10);
        // Load_val = 0 in auto mode: Tc every enabled cycle.
        a_lv = 4'd0; a_ld = 1;
        tick(1);  cmp("lit_z_q", 32'(a_q), 0);
        a_ld = 0;
        tick(1);  cmp("lit_z_tc1", 32'(a_tc), 1);
        tick(1);  cmp("lit_z_tc2", 32'(a_tc), 1);
        tick(1);  cmp("lit_z_tc3", 32'(a_tc), 1); cmp("lit_z_q3", 32'(a_q), 0);
        a_en = 0;
`else
        // Prescaled down count, PRESCALE=4.
        a_lv = 4'd5; a_ld = 1; a_en = 1;
        tick(1);  cmp("lit_ps_load", 32'(a_q), 5);
        a_ld = 0;
        tick(3);  cmp("lit_ps_hold", 32'(a_q), 5);
        tick(1);  cmp("lit_ps_step", 32'(a_q), 4);
        tick(2);
        a_en = 0;
        tick(1);  cmp("lit_ps_pause", 32'(a_q), 4);
        a_en = 1;
        tick(3);  cmp("lit_ps_restart", 32'(a_q), 4);
        tick(1);  cmp("lit_ps_step2", 32'(a_q), 3);
        tick(12); cmp("lit_ps_zero", 32'(a_q), 0);
        tick(4);  cmp("lit_ps_reload", 32'(a_q), 5); cmp("lit_ps_tc", 32'(a_tc), 1);
        tick(1);  cmp("lit_ps_tc0", 32'(a_tc), 0);
        a_en = 0;
`endif
        // WIDTH=8 up count through 255 with wrap.
        b_up = 1; b_lv = 8'd255; b_ld = 1; b_en = 1;
        tick(1);   cmp("lit_b_start", 32'(b_q), 0);
        b_ld = 0;
        tick(255); cmp("lit_b_max", 32'(b_q), 255); cmp("lit_b_tc0", 32'(b_tc), 0);
        tick(1);   cmp("lit_b_wrap", 32'(b_q), 0); cmp("lit_b_tc", 32'(b_tc), 1);
        tick(1);   cmp("lit_b_one", 32'(b_q), 1);
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
